// File: rtl/arb_pkg.sv
// Shared definitions for the two-port memory arbiter: response-owner
// encoding, port identifiers for the last-grant register, default widths.
package arb_pkg;

  localparam int AW_DEF = 32;
  localparam int DW_DEF = 32;

  // Who receives the response in the cycle after a grant
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_t;

  // Encoding of the last-grant register
  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_LS = 1'b1;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin choice. Bit 0 is the fetch port, bit 1 the
// load/store port. On a tie the port that did not win last time is picked.
module rr_pick
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  // Lone requester passes straight through; a tie goes to the other port
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (last == PORT_LS) ? 2'b01 : 2'b10;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a load/store port onto one single-port
// synchronous memory. Grants are combinational (zero arbitration latency);
// the response returns to the granted port exactly one cycle later, so one
// access per cycle can be sustained.
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int AW       = AW_DEF,
  parameter int DW       = DW_DEF,
  parameter bit LS_FIRST = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_rvalid,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_gnt,
  output logic          ls_rvalid,
  output logic [DW-1:0] ls_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  logic [1:0] pick;
  logic       last_reg;
  logic       last_next;
  owner_t     owner_reg;
  owner_t     owner_next;
  logic       resp_we_reg;
  logic       resp_we_next;

  rr_pick u_rr_pick (
    .req  ({ls_req, if_req}),
    .last (last_reg),
    .gnt  (pick)
  );

  // Grants are masked while reset is held so every output is 0 immediately
  assign if_gnt = pick[0] & reset;
  assign ls_gnt = pick[1] & reset;

  // Route the granted port onto the memory bus; idle bus is all zeros
  always_comb begin
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_addr  = ls_addr;
      mem_we    = ls_we;
      mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_addr  = if_addr;
    end
  end

  // Next-state: remember who was granted and whether it was a write
  always_comb begin
    last_next    = last_reg;
    owner_next   = OWN_NONE;
    resp_we_next = 1'b0;
    if (ls_gnt) begin
      last_next    = PORT_LS;
      owner_next   = OWN_LS;
      resp_we_next = ls_we;
    end else if (if_gnt) begin
      last_next    = PORT_IF;
      owner_next   = OWN_IF;
    end
  end

  // State registers; reset discards any pending response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_reg    <= ~LS_FIRST;
      owner_reg   <= OWN_NONE;
      resp_we_reg <= 1'b0;
    end else begin
      last_reg    <= last_next;
      owner_reg   <= owner_next;
      resp_we_reg <= resp_we_next;
    end
  end

  // Response steering: read data to the owner, writes acknowledge with 0
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    case (owner_reg)
      OWN_IF: begin
        if_rvalid = 1'b1;
        if_rdata  = mem_rdata;
      end
      OWN_LS: begin
        ls_rvalid = 1'b1;
        if (!resp_we_reg) ls_rdata = mem_rdata;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change just after the rising edge,
// outputs are checked at the falling edge.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req;
  logic          ls_we;
  logic [AW-1:0] ls_addr;
  logic [DW-1:0] ls_wdata;
  logic          ls_gnt;
  logic          ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int checks   = 0;
  int failures = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .LS_FIRST(1'b1)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_we     (ls_we),
    .ls_addr   (ls_addr),
    .ls_wdata  (ls_wdata),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .mem_addr  (mem_addr),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Check grant pair, bus and both response ports in one go
  task automatic chk_all(input string tag,
                         input logic ig, input logic lg,
                         input logic [31:0] ma, input logic mw, input logic [31:0] md,
                         input logic iv, input logic [31:0] id,
                         input logic lv, input logic [31:0] ld);
    chk({tag, ".if_gnt"},    {31'd0, if_gnt},    {31'd0, ig});
    chk({tag, ".ls_gnt"},    {31'd0, ls_gnt},    {31'd0, lg});
    chk({tag, ".mem_addr"},  mem_addr,           ma);
    chk({tag, ".mem_we"},    {31'd0, mem_we},    {31'd0, mw});
    chk({tag, ".mem_wdata"}, mem_wdata,          md);
    chk({tag, ".if_rvalid"}, {31'd0, if_rvalid}, {31'd0, iv});
    chk({tag, ".if_rdata"},  if_rdata,           id);
    chk({tag, ".ls_rvalid"}, {31'd0, ls_rvalid}, {31'd0, lv});
    chk({tag, ".ls_rdata"},  ls_rdata,           ld);
    $display("step %-12s if_gnt=%0b ls_gnt=%0b mem_addr=%0h if_rv=%0b ls_rv=%0b",
             tag, if_gnt, ls_gnt, mem_addr, if_rvalid, ls_rvalid);
  endtask

  // Advance to just after the next rising edge
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; if_req = 1'b1; if_addr = 32'h100;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h200; ls_wdata = 32'h0;
    mem_rdata = 32'hFFFF_FFFF;

    // Reset held with both ports requesting: everything must be 0
    @(negedge clk);
    chk_all("reset", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    next_cycle();
    reset = 1'b1;

    // First tie after reset: ls, if, ls
    @(negedge clk);
    chk_all("tie0", 0, 1, 32'h200, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    next_cycle(); mem_rdata = 32'hA1;
    @(negedge clk);
    chk_all("tie1", 1, 0, 32'h100, 0, 32'h0, 0, 32'h0, 1, 32'hA1);
    next_cycle(); mem_rdata = 32'hA2;
    @(negedge clk);
    chk_all("tie2", 0, 1, 32'h200, 0, 32'h0, 1, 32'hA2, 0, 32'h0);
    next_cycle(); mem_rdata = 32'hA3; if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk);
    chk_all("tie3", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'hA3);
    next_cycle(); mem_rdata = 32'h5A5A_5A5A;
    @(negedge clk);
    chk_all("idle", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);

    // Lone fetch
    next_cycle(); if_req = 1'b1; if_addr = 32'h100;
    @(negedge clk);
    chk_all("fetch0", 1, 0, 32'h100, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    next_cycle(); if_req = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk_all("fetch1", 0, 0, 32'h0, 0, 32'h0, 1, 32'hDEAD_BEEF, 0, 32'h0);

    // Store: write acknowledge returns zero data
    next_cycle(); ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'h1234_5678;
    @(negedge clk);
    chk_all("store0", 0, 1, 32'h40, 1, 32'h1234_5678, 0, 32'h0, 0, 32'h0);
    next_cycle(); ls_req = 1'b0; ls_we = 1'b0; ls_wdata = 32'h0; mem_rdata = 32'h5555_5555;
    @(negedge clk);
    chk_all("store1", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h0);

    // Dropped ls request: fetch wins (ls went last), ls withdraws
    next_cycle(); if_req = 1'b1; if_addr = 32'h180; ls_req = 1'b1; ls_addr = 32'h80;
    @(negedge clk);
    chk_all("drop0", 1, 0, 32'h180, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    next_cycle(); if_req = 1'b0; ls_req = 1'b0; mem_rdata = 32'hC0DE;
    @(negedge clk);
    chk_all("drop1", 0, 0, 32'h0, 0, 32'h0, 1, 32'hC0DE, 0, 32'h0);
    next_cycle(); mem_rdata = 32'h7777;
    @(negedge clk);
    chk_all("drop2", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    next_cycle(); if_req = 1'b1; if_addr = 32'h1C0; ls_req = 1'b1; ls_addr = 32'h84;
    @(negedge clk);
    chk_all("drop3", 0, 1, 32'h84, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    next_cycle(); if_req = 1'b0; ls_req = 1'b0; mem_rdata = 32'hB0B0;
    @(negedge clk);
    chk_all("drop4", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'hB0B0);

    // Back-to-back fetches: data presented is 0x1000 + address
    for (int k = 0; k <= 4; k++) begin
      next_cycle();
      if (k < 4) begin
        if_req = 1'b1; if_addr = 32'(4 * k);
      end else begin
        if_req = 1'b0; if_addr = 32'h0;
      end
      mem_rdata = (k == 0) ? 32'hFFFF_0000 : 32'h1000 + 32'(4 * (k - 1));
      @(negedge clk);
      chk_all($sformatf("b2b%0d", k), (k < 4), 0, (k < 4) ? 32'(4 * k) : 32'h0, 0, 32'h0,
              (k > 0), (k > 0) ? 32'h1000 + 32'(4 * (k - 1)) : 32'h0, 0, 32'h0);
    end

    // Reset in the response cycle of an ls read (ls becomes last-granted)
    next_cycle(); ls_req = 1'b1; ls_addr = 32'h300;
    @(negedge clk);
    chk_all("rst0", 0, 1, 32'h300, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    next_cycle(); if_req = 1'b1; if_addr = 32'h310; mem_rdata = 32'hBEEF;
    reset = 1'b0;
    #1;
    chk_all("rst1", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    @(negedge clk);
    chk_all("rst2", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    next_cycle(); reset = 1'b1;
    @(negedge clk);
    chk_all("rst3", 0, 1, 32'h300, 0, 32'h0, 0, 32'h0, 0, 32'h0);
    next_cycle(); if_req = 1'b0; ls_req = 1'b0; mem_rdata = 32'h600D;
    @(negedge clk);
    chk_all("rst4", 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 32'h600D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter AW, 32, address width of both requester ports and the memory port.
REQ-002 Parameter DW, 32, data width of all read/write data buses.
REQ-003 Parameter LS_FIRST, 1, port winning the first tie after reset (1 = load/store, 0 = fetch).
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset; the block is in reset while reset = 0.
REQ-006 if_req  in  1  fetch port requests a read.
REQ-007 if_addr  in  AW  fetch address.
REQ-008 if_gnt  out  1  fetch request accepted this cycle.
REQ-009 if_rvalid  out  1  fetch read data valid.
REQ-010 if_rdata  out  DW  fetch read data.
REQ-011 ls_req  in  1  load/store port requests an access.
REQ-012 ls_we  in  1  load/store access is a write.
REQ-013 ls_addr  in  AW  load/store address.
REQ-014 ls_wdata  in  DW  load/store write data.
REQ-015 ls_gnt  out  1  load/store request accepted this cycle.
REQ-016 ls_rvalid  out  1  load/store completion; read data valid, or write acknowledge.
REQ-017 ls_rdata  out  DW  load/store read data.
REQ-018 mem_addr  out  AW  address to the single-port synchronous memory.
REQ-019 mem_we  out  1  memory write enable.
REQ-020 mem_wdata  out  DW  memory write data.
REQ-021 mem_rdata  in  DW  memory read data, valid the cycle after the address is presented.

Function
REQ-022 Issue cycle:
- At most one of if_gnt/ls_gnt is high per cycle; grant is combinational from the current reqs and the last-grant register.
- The granted port's addr/we/wdata are driven onto mem_* in the same cycle.
REQ-023 Idle driving: with no grant, mem_addr = 0, mem_we = 0 and mem_wdata = 0.
REQ-024 Fetch port: if_gnt always drives mem_we = 0.
REQ-025 Single requester: a lone request is granted in the cycle it is asserted; zero arbitration latency.
REQ-026 Both requesting: the port not granted most recently wins; the last-grant register updates on every grant.
REQ-027 Fairness: a continuously requesting port waits at most one grant.
REQ-028 Response cycle: exactly one cycle after a grant, the owner's rvalid pulses high for one cycle.
REQ-029 Read data: owner's rdata = mem_rdata during the response cycle.
REQ-030 Owner register: a 2-bit register records the response owner as NONE, IF or LS.
REQ-031 Write acknowledge: ls_rvalid pulses and ls_rdata = 0.
REQ-032 Pipelining: a new grant may issue in the response cycle of the previous one; sustained throughput is one access per cycle.
REQ-033 Outside response cycles, rvalid = 0 and rdata = 0 on both ports.
REQ-034 Requester rule: req, addr, we and wdata are held stable until gnt. A req dropped before gnt creates no transaction and does not update the last-grant register.
REQ-035 The block holds no request queue; a non-granted request is simply re-arbitrated the next cycle.

Reset
REQ-036 While reset = 0:
- All outputs are 0.
- The owner register is NONE.
- The last-grant register holds the port opposite LS_FIRST.
REQ-037 Reset mid-operation: a pending response is discarded, and no rvalid is produced for it after reset deasserts.
REQ-038 First edge after release: the first rising edge after reset rises may grant normally.

Structure
REQ-039 Shared package arb_pkg:
- owner encoding OWN_NONE = 0, OWN_IF = 1, OWN_LS = 2;
- default AW/DW constants.
REQ-040 Sub-module: the two-way round-robin choice is a combinational sub-module rr_pick. rr_pick takes req[1:0] and last and outputs gnt[1:0].
REQ-041 State location: all state (last grant, owner) lives in mem_arbiter.

Verification
REQ-042 Lone fetch: if_req=1, if_addr=0x100, mem_rdata=0xDEADBEEF next cycle.
- Cycle 0: if_gnt=1, mem_addr=0x100, mem_we=0.
- Cycle 1: if_rvalid=1, if_rdata=0xDEADBEEF.
REQ-043 First tie after reset: both ports request in the first cycle with LS_FIRST=1.
- Grants go ls, then if, then ls on successive cycles.
- rvalids follow one cycle later in the same order.
REQ-044 Store: ls_we=1, ls_addr=0x40, ls_wdata=0x12345678.
- Issue cycle: mem_we=1, mem_addr=0x40, mem_wdata=0x12345678.
- Next cycle: ls_rvalid=1, ls_rdata=0.
REQ-045 Back-to-back fetches: 4 consecutive fetches at 0x0, 0x4, 0x8, 0xC with ls idle.
- Grants on cycles 0-3, if_rvalid on cycles 1-4.
- Each rdata matches the data presented for its own address.
REQ-046 Reset during response: reset=0 asserted in the cycle after a grant.
- rvalid stays 0, and all outputs are 0 immediately (asynchronous).
- After release, a tie is granted to ls first.
REQ-047 Dropped request: ls_req pulses for one cycle while a fetch wins the tie.
- No ls transaction occurs and ls_rvalid never rises.
- The next tie still favours ls.
